// File: rtl/block_transfer_arbiter_pkg.sv
// Shared definitions for the block transfer arbiter: FSM state encoding and
// width helpers used by the top and the round-robin picker.
package block_transfer_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    // Bits needed to index 'value' distinct items, never less than one.
    function automatic int ilog2(input int value);
        int bits;
        bits = 1;
        while ((1 << bits) < value) begin
            bits = bits + 1;
        end
        return bits;
    endfunction

    function automatic int words_per_block(input int bsize, input int wsize);
        return bsize / wsize;
    endfunction

endpackage

// File: rtl/block_transfer_arbiter_picker.sv
// Round-robin priority picker: the first asserted request found when scanning
// upward from ptr, wrapping modulo NREQ.
module rr_priority_picker #(
    parameter int NREQ = 4,
    parameter int IW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic            found,
    output logic [IW-1:0]   idx
);

    // Scan offsets from far to near so the nearest requester to ptr wins.
    always_comb begin
        int j;
        found = 1'b0;
        idx   = '0;
        j     = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            j     = (int'(ptr) + k) % NREQ;
            idx   = req[j] ? IW'(j) : idx;
            found = found | req[j];
        end
    end

endmodule

// File: rtl/block_transfer_arbiter.sv
// Grants one requester at a time the converter word input for exactly one
// block, rotating round-robin and padding blocks whose owner stalls too long.
module block_transfer_arbiter
    import block_transfer_arbiter_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int WSIZE   = 32,
    parameter int BSIZE   = 256,
    parameter int TIMEOUT = 64
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*WSIZE-1:0]   req_word,
    output logic [NREQ-1:0]         req_ready,
    output logic [WSIZE-1:0]        word_out,
    output logic                    send_word,
    input  logic                    input_hold,
    output logic [ilog2(NREQ)-1:0]  grant_id,
    output logic                    busy,
    output logic                    block_done,
    output logic                    pad_error
);

    localparam int WPERB = words_per_block(BSIZE, WSIZE);
    localparam int CW    = ilog2(WPERB);
    localparam int SW    = ilog2(TIMEOUT + 1);
    localparam int IW    = ilog2(NREQ);

    state_t            state_r;
    state_t            next_state_s;
    logic [IW-1:0]     owner_r;
    logic [IW-1:0]     rr_ptr_r;
    logic [IW-1:0]     pick_idx_s;
    logic              pick_found_s;
    logic [CW-1:0]     count_r;
    logic [SW-1:0]     stall_r;
    logic              padding_s;
    logic              accept_s;
    logic              last_s;
    logic [WSIZE-1:0]  owner_word_s;
    logic [IW-1:0]     next_ptr_s;

    rr_priority_picker #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_picker (
        .req   (req_valid),
        .ptr   (rr_ptr_r),
        .found (pick_found_s),
        .idx   (pick_idx_s)
    );

    // Once the stall budget is spent the arbiter supplies zero words itself.
    assign padding_s    = (TIMEOUT != 0) && (stall_r == SW'(TIMEOUT));
    assign owner_word_s = req_word[int'(owner_r) * WSIZE +: WSIZE];
    assign accept_s     = (state_r == ST_GRANT) && !input_hold
                          && (padding_s || req_valid[owner_r]);
    assign last_s       = (count_r == CW'(WPERB - 1));
    assign next_ptr_s   = (owner_r == IW'(NREQ - 1)) ? '0 : owner_r + IW'(1);

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state and combinational ready decode.
    always_comb begin
        next_state_s = state_r;
        req_ready    = '0;
        case (state_r)
            ST_IDLE: begin
                next_state_s = pick_found_s ? ST_GRANT : ST_IDLE;
            end
            ST_GRANT: begin
                if (!input_hold && !padding_s) begin
                    req_ready[owner_r] = 1'b1;
                end else begin
                    req_ready = '0;
                end
                next_state_s = (accept_s && last_s) ? ST_RELEASE : ST_GRANT;
            end
            ST_RELEASE: begin
                next_state_s = ST_IDLE;
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // Grant bookkeeping, counters and registered converter-side outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            owner_r    <= '0;
            rr_ptr_r   <= '0;
            count_r    <= '0;
            stall_r    <= '0;
            word_out   <= '0;
            send_word  <= 1'b0;
            block_done <= 1'b0;
            busy       <= 1'b0;
            pad_error  <= 1'b0;
        end else begin
            send_word  <= accept_s;
            block_done <= accept_s && last_s;
            if (accept_s) begin
                word_out <= padding_s ? '0 : owner_word_s;
            end
            case (state_r)
                ST_IDLE: begin
                    if (pick_found_s) begin
                        owner_r <= pick_idx_s;
                        busy    <= 1'b1;
                        count_r <= '0;
                        stall_r <= '0;
                    end
                end
                ST_GRANT: begin
                    if (accept_s) begin
                        count_r <= last_s ? '0 : count_r + CW'(1);
                        if (padding_s) begin
                            pad_error <= 1'b1;
                        end else begin
                            stall_r <= '0;
                        end
                    end else if (!padding_s && (TIMEOUT != 0) && !input_hold
                                 && !req_valid[owner_r]) begin
                        stall_r <= stall_r + SW'(1);
                    end
                end
                ST_RELEASE: begin
                    busy     <= 1'b0;
                    rr_ptr_r <= next_ptr_s;
                end
                default: begin
                    busy <= 1'b0;
                end
            endcase
        end
    end

    assign grant_id = owner_r;

endmodule

// File: tb/tb_block_transfer_arbiter.sv
// Directed bench for block_transfer_arbiter: an 8-word-block instance with a
// short timeout and a one-word-block instance, both with hand-computed checks.
module tb_block_transfer_arbiter;

    typedef struct packed {
        logic [31:0] w;
        logic [1:0]  g;
        logic        d;
    } ent_t;

    logic         clock = 1'b0;
    logic         reset;
    logic [3:0]   req_valid, req_valid2;
    logic [127:0] req_word, req_word2;
    logic [3:0]   req_ready, req_ready2;
    logic [31:0]  word_out, word_out2;
    logic         send_word, send_word2;
    logic         input_hold, input_hold2;
    logic [1:0]   grant_id, grant_id2;
    logic         busy, busy2;
    logic         block_done, block_done2;
    logic         pad_error, pad_error2;

    int   seq[4];
    int   seq2[4];
    int   tests = 0;
    int   fails = 0;
    ent_t log1[$];
    ent_t log2[$];
    int   ord[3] = '{0, 1, 3};

    always #5 clock = ~clock;

    block_transfer_arbiter #(.NREQ(4), .WSIZE(32), .BSIZE(256), .TIMEOUT(4)) dut (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_word(req_word),
        .req_ready(req_ready), .word_out(word_out), .send_word(send_word),
        .input_hold(input_hold), .grant_id(grant_id), .busy(busy),
        .block_done(block_done), .pad_error(pad_error)
    );

    block_transfer_arbiter #(.NREQ(4), .WSIZE(32), .BSIZE(32), .TIMEOUT(0)) dut1w (
        .clock(clock), .reset(reset), .req_valid(req_valid2), .req_word(req_word2),
        .req_ready(req_ready2), .word_out(word_out2), .send_word(send_word2),
        .input_hold(input_hold2), .grant_id(grant_id2), .busy(busy2),
        .block_done(block_done2), .pad_error(pad_error2)
    );

    always @(negedge clock) begin
        if (send_word === 1'b1) log1.push_back('{w: word_out, g: grant_id, d: block_done});
        if (send_word2 === 1'b1) log2.push_back('{w: word_out2, g: grant_id2, d: block_done2});
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests = tests + 1;
        assert (obs === exp) else begin
            fails = fails + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic refresh();
        for (int i = 0; i < 4; i++) begin
            req_word[i*32 +: 32]  = 32'(i * 256 + seq[i]);
            req_word2[i*32 +: 32] = 32'(i * 256 + seq2[i]);
        end
    endtask

    task automatic clear_seq();
        for (int i = 0; i < 4; i++) begin
            seq[i]  = 0;
            seq2[i] = 0;
        end
        refresh();
    endtask

    task automatic step();
        logic [3:0] f1;
        logic [3:0] f2;
        @(negedge clock);
        f1 = req_valid & req_ready;
        f2 = req_valid2 & req_ready2;
        @(posedge clock);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (f1[i]) seq[i] = seq[i] + 1;
            if (f2[i]) seq2[i] = seq2[i] + 1;
        end
        refresh();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        req_valid = '0;
        req_valid2 = '0;
        input_hold = 1'b0;
        input_hold2 = 1'b0;
        clear_seq();
        step();
        step();
        reset = 1'b1;
        step();
        log1.delete();
        log2.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        req_valid = '0;
        req_valid2 = '0;
        input_hold = 1'b0;
        input_hold2 = 1'b0;
        clear_seq();
        step();
        step();
        check("rst_word_out", word_out, 32'h0);
        check("rst_send_word", 32'(send_word), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_grant_id", 32'(grant_id), 32'h0);
        check("rst_block_done", 32'(block_done), 32'h0);
        check("rst_pad_error", 32'(pad_error), 32'h0);
        check("rst_req_ready", 32'(req_ready), 32'h0);
        reset = 1'b1;
        step();
        log1.delete();
        log2.delete();

        // 1) single source streams a full block
        req_valid = 4'b0100;
        step();
        check("t1_busy", 32'(busy), 32'h1);
        check("t1_gid", 32'(grant_id), 32'h2);
        check("t1_ready", 32'(req_ready), 32'h4);
        for (int n = 0; n < 40 && seq[2] < 8; n++) step();
        req_valid = '0;
        check("t1_accepts", 32'(seq[2]), 32'h8);
        check("t1_done", 32'(block_done), 32'h1);
        check("t1_busy_in_release", 32'(busy), 32'h1);
        check("t1_last_word", word_out, 32'h207);
        step();
        check("t1_busy_drop", 32'(busy), 32'h0);
        check("t1_done_pulse", 32'(block_done), 32'h0);
        check("t1_no_strobe", 32'(send_word), 32'h0);
        step();
        check("t1_nstrobe", 32'(log1.size()), 32'h8);
        for (int j = 0; j < log1.size(); j++) begin
            check("t1_word", log1[j].w, 32'(32'h200 + j));
            check("t1_gid_log", 32'(log1[j].g), 32'h2);
            check("t1_done_log", 32'(log1[j].d), 32'(j == 7));
        end

        // 2) three contending sources rotate block by block
        do_reset();
        req_valid = 4'b1011;
        for (int n = 0; n < 400 && (seq[0] + seq[1] + seq[3]) < 48; n++) step();
        req_valid = '0;
        check("t2_accepts", 32'(seq[0] + seq[1] + seq[3]), 32'd48);
        step();
        step();
        check("t2_nstrobe", 32'(log1.size()), 32'd48);
        for (int j = 0; j < log1.size(); j++) begin
            check("t2_word", log1[j].w,
                  32'(ord[(j / 8) % 3] * 256 + ((j / 8) >= 3 ? 8 : 0) + j % 8));
            check("t2_gid", 32'(log1[j].g), 32'(ord[(j / 8) % 3]));
            check("t2_done", 32'(log1[j].d), 32'(j % 8 == 7));
        end

        // 3) converter backpressure mid-block, with the source idle meanwhile
        do_reset();
        req_valid = 4'b0001;
        for (int n = 0; n < 40 && seq[0] < 4; n++) step();
        input_hold = 1'b1;
        req_valid = '0;
        for (int k = 0; k < 5; k++) begin
            step();
            check("t3_hold_no_strobe", 32'(send_word), 32'h0);
            check("t3_hold_word_stable", word_out, 32'h3);
            check("t3_hold_ready", 32'(req_ready), 32'h0);
        end
        input_hold = 1'b0;
        req_valid = 4'b0001;
        for (int n = 0; n < 40 && seq[0] < 8; n++) step();
        req_valid = '0;
        check("t3_accepts", 32'(seq[0]), 32'h8);
        step();
        step();
        check("t3_nstrobe", 32'(log1.size()), 32'h8);
        for (int j = 0; j < log1.size(); j++) begin
            check("t3_word", log1[j].w, 32'(j));
        end
        check("t3_no_pad", 32'(pad_error), 32'h0);

        // 4) owner stalls past the timeout and the block is zero-padded
        do_reset();
        req_valid = 4'b0010;
        for (int n = 0; n < 40 && seq[1] < 3; n++) step();
        req_valid = '0;
        for (int k = 0; k < 4; k++) step();
        check("t4_stall_no_strobe", 32'(send_word), 32'h0);
        check("t4_stall_no_pad_yet", 32'(pad_error), 32'h0);
        check("t4_pad_ready_low", 32'(req_ready), 32'h0);
        step();
        check("t4_pad_strobe", 32'(send_word), 32'h1);
        check("t4_pad_word", word_out, 32'h0);
        check("t4_pad_error", 32'(pad_error), 32'h1);
        req_valid = 4'b0110;
        for (int k = 0; k < 4; k++) step();
        check("t4_pad_done", 32'(block_done), 32'h1);
        for (int n = 0; n < 60 && seq[2] < 8; n++) step();
        req_valid = '0;
        check("t4_owner_blocked", 32'(seq[1]), 32'h3);
        step();
        step();
        check("t4_nstrobe", 32'(log1.size()), 32'd16);
        for (int j = 0; j < log1.size(); j++) begin
            if (j < 8) begin
                check("t4_word", log1[j].w, (j < 3) ? 32'(32'h100 + j) : 32'h0);
                check("t4_gid", 32'(log1[j].g), 32'h1);
            end else begin
                check("t4_next_word", log1[j].w, 32'(32'h200 + j - 8));
                check("t4_next_gid", 32'(log1[j].g), 32'h2);
            end
            check("t4_done", 32'(log1[j].d), 32'(j % 8 == 7));
        end

        // 5) asynchronous reset in the middle of a block
        req_valid = 4'b1000;
        for (int n = 0; n < 40 && seq[3] < 6; n++) step();
        check("t5_pre_busy", 32'(busy), 32'h1);
        reset = 1'b0;
        #1;
        check("t5_rst_word_out", word_out, 32'h0);
        check("t5_rst_send_word", 32'(send_word), 32'h0);
        check("t5_rst_busy", 32'(busy), 32'h0);
        check("t5_rst_gid", 32'(grant_id), 32'h0);
        check("t5_rst_done", 32'(block_done), 32'h0);
        check("t5_rst_pad_error", 32'(pad_error), 32'h0);
        check("t5_rst_ready", 32'(req_ready), 32'h0);
        clear_seq();
        log1.delete();
        req_valid = 4'b1010;
        step();
        reset = 1'b1;
        step();
        check("t5_first_busy", 32'(busy), 32'h1);
        check("t5_first_gid", 32'(grant_id), 32'h1);
        for (int n = 0; n < 40 && seq[1] < 8; n++) step();
        req_valid = '0;
        step();
        step();
        check("t5_nstrobe", 32'(log1.size()), 32'h8);
        for (int j = 0; j < log1.size(); j++) begin
            check("t5_word", log1[j].w, 32'(32'h100 + j));
            check("t5_gid", 32'(log1[j].g), 32'h1);
        end
        check("t5_src3_idle", 32'(seq[3]), 32'h0);
        check("t5_pad_clear", 32'(pad_error), 32'h0);

        // 6) one-word blocks with every source requesting
        req_valid2 = 4'b1111;
        for (int n = 0; n < 100 && (seq2[0] + seq2[1] + seq2[2] + seq2[3]) < 8; n++) step();
        req_valid2 = '0;
        check("t6_accepts", 32'(seq2[0] + seq2[1] + seq2[2] + seq2[3]), 32'h8);
        step();
        step();
        step();
        check("t6_nstrobe", 32'(log2.size()), 32'h8);
        for (int j = 0; j < log2.size(); j++) begin
            check("t6_word", log2[j].w, 32'((j % 4) * 256 + j / 4));
            check("t6_gid", 32'(log2[j].g), 32'(j % 4));
            check("t6_done", 32'(log2[j].d), 32'h1);
        end
        check("t6_no_pad", 32'(pad_error2), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
